keyboard_hex_entry: RTL and testbench

Sequencer between the PS/2 byte receiver and the hex-digit decoder. It consumes raw scan-code bytes and tracks make/break and extended prefixes. It suppresses typematic repeats and assembles hex digits into an entry register with backspace, escape and enter editing. A committed value is handed downstream over a valid/ready handshake.

---
 rtl/keyboard_hex_entry_pkg.sv | 36 +++
 rtl/keyboard_hex_entry_decoder.sv | 31 +++
 rtl/keyboard_hex_entry.sv | 157 +++++++++++++++
 tb/tb_keyboard_hex_entry.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keyboard_hex_entry_pkg.sv
// Shared scan-code constants, prefix-FSM state type and the hex-key membership
// test used by keyboard_hex_entry.
package keyboard_pkg;

  localparam logic [7:0] KC_E0    = 8'hE0;
  localparam logic [7:0] KC_F0    = 8'hF0;
  localparam logic [7:0] KC_ENTER = 8'h5A;
  localparam logic [7:0] KC_BKSP  = 8'h66;
  localparam logic [7:0] KC_ESC   = 8'h76;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } pfx_state_e;

  // Main-row 0-9 then A-F, index equals the digit value.
  localparam logic [0:15][7:0] MAIN_HEX = {
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
    8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B
  };

  localparam logic [0:9][7:0] PAD_HEX = {
    8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D
  };

  function automatic logic is_hex(input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 16; i++) if (MAIN_HEX[i] == code) hit = 1'b1;
    for (int i = 0; i < 10; i++) if (PAD_HEX[i] == code) hit = 1'b1;
    return hit;
  endfunction

endpackage

// File: rtl/keyboard_hex_entry_decoder.sv
// Scan-code to hex-digit decoder; unknown codes decode to 0, so callers must
// qualify the result with a separate hex-key flag.
module keyboard_decoder (
  input  logic [7:0] code,
  output logic [3:0] digit
);

  always_comb begin
    digit = 4'h0;
    case (code)
      8'h45, 8'h70: digit = 4'h0;
      8'h16, 8'h69: digit = 4'h1;
      8'h1E, 8'h72: digit = 4'h2;
      8'h26, 8'h7A: digit = 4'h3;
      8'h25, 8'h6B: digit = 4'h4;
      8'h2E, 8'h73: digit = 4'h5;
      8'h36, 8'h74: digit = 4'h6;
      8'h3D, 8'h6C: digit = 4'h7;
      8'h3E, 8'h75: digit = 4'h8;
      8'h46, 8'h7D: digit = 4'h9;
      8'h1C:        digit = 4'hA;
      8'h32:        digit = 4'hB;
      8'h21:        digit = 4'hC;
      8'h23:        digit = 4'hD;
      8'h24:        digit = 4'hE;
      8'h2B:        digit = 4'hF;
      default:      digit = 4'h0;
    endcase
  end

endmodule

// File: rtl/keyboard_hex_entry.sv
// Turns raw PS/2 scan-code bytes into an editable hex entry register and hands
// committed values downstream over a valid/ready slot.
module keyboard_hex_entry
  import keyboard_pkg::*;
#(
  parameter  int DIGITS = 4,
  localparam int W      = 4 * DIGITS,
  localparam int CW     = $clog2(DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    kcode,
  input  logic          kvalid,
  output logic [W-1:0]  value,
  output logic [CW-1:0] count,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          err
);

  pfx_state_e    state_q, state_d;
  logic [8:0]    held_q, held_d;
  logic          held_valid_q, held_valid_d;
  logic [W-1:0]  value_q, value_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          err_q, err_d;

  logic          ev_make, ev_rel, ev_ext;
  logic [8:0]    key;
  logic [3:0]    dec_digit;
  logic [3:0]    hex_digit;
  logic          key_is_hex;
  logic          repeat_key;
  logic          slot_free;

  keyboard_decoder u_dec (
    .code  (kcode),
    .digit (dec_digit)
  );

  assign key_is_hex = is_hex(kcode);
  assign hex_digit  = key_is_hex ? dec_digit : 4'h0;
  assign key        = {ev_ext, kcode};
  assign repeat_key = held_valid_q && (held_q == key);
  // An enter may land in the same cycle the current slot is being accepted.
  assign slot_free  = !out_valid_q || out_ready;

  always_comb begin
    state_d      = state_q;
    ev_make      = 1'b0;
    ev_rel       = 1'b0;
    ev_ext       = 1'b0;
    if (kvalid) begin
      case (state_q)
        IDLE: begin
          if (kcode == KC_F0)      state_d = BRK;
          else if (kcode == KC_E0) state_d = EXT;
          else                     ev_make = 1'b1;
        end
        EXT: begin
          ev_ext = 1'b1;
          if (kcode == KC_F0) state_d = EXT_BRK;
          else begin
            ev_make = 1'b1;
            state_d = IDLE;
          end
        end
        BRK: begin
          ev_rel  = 1'b1;
          state_d = IDLE;
        end
        EXT_BRK: begin
          ev_ext  = 1'b1;
          ev_rel  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    held_d       = held_q;
    held_valid_d = held_valid_q;
    value_d      = value_q;
    count_d      = count_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    err_d        = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (ev_rel && repeat_key) held_valid_d = 1'b0;

    if (ev_make && !repeat_key) begin
      held_d       = key;
      held_valid_d = 1'b1;
      if (!ev_ext && key_is_hex) begin
        if (count_q != CW'(DIGITS)) begin
          value_d = (value_q << 4) | W'(hex_digit);
          count_d = count_q + CW'(1);
        end else begin
          err_d = 1'b1;
        end
      end else if (!ev_ext && kcode == KC_BKSP) begin
        if (count_q != '0) begin
          value_d = value_q >> 4;
          count_d = count_q - CW'(1);
        end
      end else if (!ev_ext && kcode == KC_ESC) begin
        value_d = '0;
        count_d = '0;
      end else if (kcode == KC_ENTER && count_q != '0) begin
        if (slot_free) begin
          out_data_d  = value_q;
          out_valid_d = 1'b1;
          value_d     = '0;
          count_d     = '0;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      held_q       <= '0;
      held_valid_q <= 1'b0;
      value_q      <= '0;
      count_q      <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      held_q       <= held_d;
      held_valid_q <= held_valid_d;
      value_q      <= value_d;
      count_q      <= count_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      err_q        <= err_d;
    end
  end

  assign value     = value_q;
  assign count     = count_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_keyboard_hex_entry.sv
// Scoreboard bench for keyboard_hex_entry: a key-level reference model queues
// expected per-cycle state and committed values; a monitor checks them.
module tb_keyboard_hex_entry;

  localparam int DIGITS = 4;
  localparam int W      = 16;
  localparam int CW     = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    kcode = 8'h00;
  logic          kvalid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  value;
  logic [CW-1:0] count;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          err;

  always #5 clk = ~clk;

  keyboard_hex_entry #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .kcode     (kcode),
    .kvalid    (kvalid),
    .value     (value),
    .count     (count),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  typedef struct {
    logic [W-1:0]  value;
    logic [CW-1:0] count;
    logic          ov;
    logic [W-1:0]  od;
    logic          err;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] commit_q[$];
  int           checks = 0;
  int           passes = 0;

  // Reference model: digits as a list, a pressed key as an integer id.
  int  digs[$];
  int  hexmap[int];
  bit  pend_brk, pend_ext;
  int  held;
  bit  slot_full;
  int  slot_data;
  bit  cur_ready;
  int  main_codes[16] = '{'h45, 'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D,
                          'h3E, 'h46, 'h1C, 'h32, 'h21, 'h23, 'h24, 'h2B};
  int  pad_codes[10]  = '{'h70, 'h69, 'h72, 'h7A, 'h6B, 'h73, 'h74, 'h6C, 'h75, 'h7D};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  function automatic int mval();
    int v = 0;
    foreach (digs[i]) v = v * 16 + digs[i];
    return v;
  endfunction

  task automatic push_exp(input bit e_err);
    exp_t e;
    e.value = W'(mval());
    e.count = CW'(digs.size());
    e.ov    = slot_full;
    e.od    = W'(slot_data);
    e.err   = e_err;
    exp_q.push_back(e);
  endtask

  task automatic model_step(input bit kv, input int code, input bit rdy);
    bit e_err = 1'b0;
    int k;
    if (slot_full && rdy) slot_full = 1'b0;
    if (kv) begin
      if (!pend_brk && code == 'hF0) pend_brk = 1'b1;
      else if (!pend_brk && !pend_ext && code == 'hE0) pend_ext = 1'b1;
      else begin
        k = (pend_ext ? 256 : 0) + code;
        if (pend_brk) begin
          if (held == k) held = -1;
        end else if (held != k) begin
          held = k;
          if (k < 256 && hexmap.exists(k)) begin
            if (digs.size() < DIGITS) digs.push_back(hexmap[k]);
            else e_err = 1'b1;
          end else if (k == 'h66) begin
            if (digs.size() > 0) void'(digs.pop_back());
          end else if (k == 'h76) begin
            digs.delete();
          end else if (code == 'h5A && digs.size() > 0) begin
            if (!slot_full) begin
              slot_full = 1'b1;
              slot_data = mval();
              commit_q.push_back(W'(slot_data));
              digs.delete();
            end else e_err = 1'b1;
          end
        end
        pend_brk = 1'b0;
        pend_ext = 1'b0;
      end
    end
    push_exp(e_err);
  endtask

  task automatic drive(input bit kv, input logic [7:0] b);
    @(negedge clk);
    #1;
    kvalid    = kv;
    kcode     = b;
    out_ready = cur_ready;
    model_step(kv, int'(b), cur_ready);
  endtask

  task automatic send(input logic [7:0] b);
    drive(1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send(s[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst    = 1'b1;
    kvalid = 1'b0;
    digs.delete();
    pend_brk  = 1'b0;
    pend_ext  = 1'b0;
    held      = -1;
    slot_full = 1'b0;
    slot_data = 0;
    commit_q.delete();
    push_exp(1'b0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    out_ready = cur_ready;
    model_step(1'b0, 0, cur_ready);
  endtask

  // Monitor: per-cycle state, plus accepted commits popped on each handshake.
  initial begin
    exp_t         e;
    logic         pov;
    logic [W-1:0] pod;
    pov = 1'b0;
    pod = '0;
    forever begin
      @(negedge clk);
      if (!rst && pov && out_ready) begin
        if (commit_q.size() == 0) chk("commit_expected", 32'd1, 32'd0);
        else chk("commit_data", pod, commit_q.pop_front());
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("value", value, e.value);
        chk("count", count, e.count);
        chk("out_valid", out_valid, e.ov);
        chk("out_data", out_data, e.od);
        chk("err", err, e.err);
      end
      pov = out_valid;
      pod = out_data;
    end
  end

  initial begin
    logic [7:0] b;
    int r;
    foreach (main_codes[i]) hexmap[main_codes[i]] = i;
    foreach (pad_codes[i]) hexmap[pad_codes[i]] = i;
    held = -1;
    cur_ready = 1'b1;
    do_reset();
    chk("reset_value", value, 16'h0);

    send_seq('{8'h16, 8'hF0, 8'h16, 8'h1E, 8'hF0, 8'h1E, 8'h1C, 8'hF0, 8'h1C,
               8'h5A, 8'hF0, 8'h5A});
    idle(3);
    chk("t1_value", value, 16'h0);
    chk("t1_count", count, 3'd0);

    send_seq('{8'h16, 8'h16, 8'h16, 8'hF0, 8'h16, 8'h16});
    idle(1);
    chk("typematic_value", value, 16'h0011);
    chk("typematic_count", count, 3'd2);

    send_seq('{8'hF0, 8'h16, 8'h76, 8'hF0, 8'h76,
               8'h16, 8'hF0, 8'h16, 8'h1E, 8'hF0, 8'h1E, 8'h26, 8'hF0, 8'h26,
               8'h25, 8'hF0, 8'h25, 8'h2E, 8'hF0, 8'h2E});
    idle(1);
    chk("full_value", value, 16'h1234);
    send_seq('{8'h66, 8'hF0, 8'h66});
    idle(1);
    chk("bksp_value", value, 16'h0123);
    chk("bksp_count", count, 3'd3);
    send_seq('{8'h76, 8'hF0, 8'h76});
    idle(1);
    chk("esc_count", count, 3'd0);

    cur_ready = 1'b0;
    send_seq('{8'h1C, 8'hF0, 8'h1C, 8'h32, 8'hF0, 8'h32, 8'h5A, 8'hF0, 8'h5A});
    idle(2);
    chk("busy_commit", out_data, 16'h00AB);
    send_seq('{8'h21, 8'hF0, 8'h21, 8'hE0, 8'h5A});
    idle(2);
    chk("busy_hold_data", out_data, 16'h00AB);
    chk("busy_hold_value", value, 16'h000C);
    send_seq('{8'hE0, 8'hF0, 8'h5A});
    cur_ready = 1'b1;
    send(8'h5A);
    cur_ready = 1'b0;
    idle(2);
    chk("swap_data", out_data, 16'h000C);
    chk("swap_valid", out_valid, 1'b1);
    send_seq('{8'hF0, 8'h5A});
    cur_ready = 1'b1;
    idle(3);

    send_seq('{8'hE0, 8'h70, 8'hE0, 8'hF0, 8'h70});
    idle(1);
    chk("ext_value", value, 16'h0);
    send(8'hF0);
    do_reset();
    send(8'h45);
    idle(1);
    chk("pfx_rst_value", value, 16'h0);
    chk("pfx_rst_count", count, 3'd1);
    send_seq('{8'hF0, 8'h45});

    send_seq('{8'h76, 8'hF0, 8'h76, 8'h69, 8'hF0, 8'h69, 8'h7D, 8'hF0, 8'h7D});
    idle(1);
    chk("keypad_value", value, 16'h0019);
    send_seq('{8'h76, 8'hF0, 8'h76, 8'h5A, 8'hF0, 8'h5A});
    idle(2);
    chk("empty_enter", out_valid, 1'b0);

    for (int i = 0; i < 500; i++) begin
      r = $urandom % 10;
      case (r)
        0, 1: b = 8'(main_codes[$urandom % 16]);
        2:    b = 8'(pad_codes[$urandom % 10]);
        3:    b = 8'(main_codes[$urandom % 4]);
        4:    b = 8'hF0;
        5:    b = 8'hE0;
        6:    b = 8'h66;
        7:    b = 8'h76;
        8:    b = 8'h5A;
        default: b = 8'($urandom);
      endcase
      cur_ready = ($urandom % 3) != 0;
      drive(($urandom % 4) != 0, b);
    end

    cur_ready = 1'b1;
    idle(6);
    @(negedge clk);
    #1;
    chk("commits_drained", commit_q.size(), 32'd0);
    chk("expects_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
